// File: rtl/rojoblaze_defs.sv
// Shared RojoBlaze decode definitions: opcode map, condition codes,
// decoded packet layout and small decode helpers.
// The packet gains an 'illegal' field when DECODE_ILLEGAL_TRAP_EN is defined.
package rojoblaze_defs;

    localparam int OPC_W         = 6;
    localparam int PKT_DATA_W    = 8;
    localparam int PKT_REG_SEL_W = 4;
    localparam int PKT_ADDR_W    = 10;

    typedef enum logic [OPC_W-1:0] {
        LOAD_CONST    = 6'h00,
        LOAD_REG      = 6'h01,
        INPUT_CONST   = 6'h04,
        INPUT_REG     = 6'h05,
        FETCH_CONST   = 6'h06,
        FETCH_REG     = 6'h07,
        AND_CONST     = 6'h0A,
        AND_REG       = 6'h0B,
        OR_CONST      = 6'h0C,
        OR_REG        = 6'h0D,
        XOR_CONST     = 6'h0E,
        XOR_REG       = 6'h0F,
        TEST_CONST    = 6'h12,
        TEST_REG      = 6'h13,
        COMPARE_CONST = 6'h14,
        COMPARE_REG   = 6'h15,
        ADD_CONST     = 6'h18,
        ADD_REG       = 6'h19,
        ADDCY_CONST   = 6'h1A,
        ADDCY_REG     = 6'h1B,
        SUB_CONST     = 6'h1C,
        SUB_REG       = 6'h1D,
        SUBCY_CONST   = 6'h1E,
        SUBCY_REG     = 6'h1F,
        SHIFT_OP      = 6'h20,
        RETURN_UNCOND = 6'h2A,
        RETURN_COND   = 6'h2B,
        OUTPUT_CONST  = 6'h2C,
        OUTPUT_REG    = 6'h2D,
        STORE_CONST   = 6'h2E,
        STORE_REG     = 6'h2F,
        CALL_UNCOND   = 6'h30,
        CALL_COND     = 6'h31,
        JUMP_UNCOND   = 6'h34,
        JUMP_COND     = 6'h35,
        RETURN_I_SET  = 6'h38,
        INTERRUPT_SET = 6'h3C
    } opcode_instr_t;

    typedef enum logic [1:0] {
        COND_Z  = 2'b00,
        COND_NZ = 2'b01,
        COND_C  = 2'b10,
        COND_NC = 2'b11
    } cond_t;

    typedef struct packed {
        opcode_instr_t            op;
        logic [PKT_REG_SEL_W-1:0] sx;
        logic [PKT_REG_SEL_W-1:0] sy;
        logic [PKT_DATA_W-1:0]    kk;
        logic [PKT_ADDR_W-1:0]    addr;
        logic [3:0]               shift;
        logic                     is_const;
        logic                     writes_reg;
        logic                     branch_taken;
        logic [PKT_ADDR_W-1:0]    pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic                     illegal;
`endif
    } decode_pkt_t;

    function automatic logic cond_met(logic [1:0] cond, logic z, logic c);
        case (cond)
            COND_Z:  return z;
            COND_NZ: return ~z;
            COND_C:  return c;
            default: return ~c;
        endcase
    endfunction

    function automatic logic is_cond_op(opcode_instr_t op);
        return (op == JUMP_COND) || (op == CALL_COND) || (op == RETURN_COND);
    endfunction

    function automatic logic is_legal_op(logic [OPC_W-1:0] opc);
        case (opc)
            LOAD_CONST, LOAD_REG, INPUT_CONST, INPUT_REG, FETCH_CONST, FETCH_REG,
            AND_CONST, AND_REG, OR_CONST, OR_REG, XOR_CONST, XOR_REG,
            TEST_CONST, TEST_REG, COMPARE_CONST, COMPARE_REG,
            ADD_CONST, ADD_REG, ADDCY_CONST, ADDCY_REG,
            SUB_CONST, SUB_REG, SUBCY_CONST, SUBCY_REG, SHIFT_OP,
            RETURN_UNCOND, RETURN_COND, OUTPUT_CONST, OUTPUT_REG,
            STORE_CONST, STORE_REG, CALL_UNCOND, CALL_COND,
            JUMP_UNCOND, JUMP_COND, RETURN_I_SET, INTERRUPT_SET: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rojoblaze_skid_buf.sv
// One-deep skid buffer: an output register plus one spill register.
// in_ready comes straight from the spill-register state, so it never depends
// on out_ready combinationally. flush empties both stages and wins over a
// simultaneous output handshake.
module rojoblaze_skid_buf #(
    parameter type pkt_t = logic [7:0]
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  pkt_t in_pkt,
    output logic out_valid,
    input  logic out_ready,
    output pkt_t out_pkt
);

    logic skid_valid;
    pkt_t skid_pkt;
    logic accept;

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;

    // Output/spill register update: drain spill first, otherwise load input or spill on stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_pkt    <= '0;
            skid_valid <= 1'b0;
            skid_pkt   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_pkt    <= skid_pkt;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_pkt   <= in_pkt;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_pkt   <= in_pkt;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/rojoblaze_decode_stage.sv
// RojoBlaze decode stage: splits fetch words into decoded packets, resolves
// branch conditions against Z/C at accept time, tracks interrupt enable and
// hands packets to execute through a one-deep skid buffer.
// Optional: DECODE_ILLEGAL_TRAP_EN adds out_illegal and illegal_cnt.
// Packet field widths come from rojoblaze_defs; keep DATA_W/REG_SEL_W/ADDR_W
// equal to the package widths, and ADDR_W <= REG_SEL_W + DATA_W.
module rojoblaze_decode_stage
    import rojoblaze_defs::*;
#(
    parameter int  DATA_W    = PKT_DATA_W,
    parameter int  REG_SEL_W = PKT_REG_SEL_W,
    parameter int  ADDR_W    = PKT_ADDR_W,
    localparam int INSTR_W   = OPC_W + REG_SEL_W + DATA_W
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [INSTR_W-1:0]             in_instr,
    input  logic [ADDR_W-1:0]              in_pc,
    input  logic                           flag_z,
    input  logic                           flag_c,
    input  logic                           flags_pending,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$bits(decode_pkt_t)-1:0] out_pkt,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                           out_illegal,
    output logic [7:0]                     illegal_cnt,
`endif
    output logic                           int_enable
);

    opcode_instr_t opc;
    decode_pkt_t   dec_pkt;
    decode_pkt_t   out_pkt_s;
    logic          data_op;
    logic          skid_ready;
    logic          hazard;
    logic          accept;

    // Field split and per-opcode classification of the word on the fetch side
    always_comb begin
        opc     = opcode_instr_t'(in_instr[INSTR_W-1 -: OPC_W]);
        data_op = 1'b0;
        dec_pkt = '0;
        dec_pkt.op   = opc;
        dec_pkt.sx   = in_instr[DATA_W +: REG_SEL_W];
        dec_pkt.sy   = in_instr[DATA_W-1 -: REG_SEL_W];
        dec_pkt.kk   = in_instr[DATA_W-1:0];
        dec_pkt.addr = in_instr[ADDR_W-1:0];
        dec_pkt.pc   = in_pc;
        case (opc)
            LOAD_CONST, LOAD_REG, AND_CONST, AND_REG, OR_CONST, OR_REG,
            XOR_CONST, XOR_REG, ADD_CONST, ADD_REG, ADDCY_CONST, ADDCY_REG,
            SUB_CONST, SUB_REG, SUBCY_CONST, SUBCY_REG, SHIFT_OP,
            INPUT_CONST, INPUT_REG, FETCH_CONST, FETCH_REG: begin
                data_op            = 1'b1;
                dec_pkt.writes_reg = 1'b1;
            end
            TEST_CONST, TEST_REG, COMPARE_CONST, COMPARE_REG,
            OUTPUT_CONST, OUTPUT_REG, STORE_CONST, STORE_REG: begin
                data_op = 1'b1;
            end
            JUMP_UNCOND, CALL_UNCOND, RETURN_UNCOND: begin
                dec_pkt.branch_taken = 1'b1;
            end
            JUMP_COND, CALL_COND, RETURN_COND: begin
                dec_pkt.branch_taken = cond_met(in_instr[DATA_W+REG_SEL_W-1 -: 2], flag_z, flag_c);
            end
            default: begin
            end
        endcase
        dec_pkt.is_const = data_op & ~in_instr[INSTR_W-OPC_W];
        if (opc == SHIFT_OP)
            dec_pkt.shift = in_instr[3:0];
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec_pkt.illegal = ~is_legal_op(in_instr[INSTR_W-1 -: OPC_W]);
`endif
    end

    // A conditional branch cannot be resolved while execute still owes us flags
    assign hazard   = flags_pending & is_cond_op(opc);
    assign in_ready = skid_ready & ~hazard;
    assign accept   = in_valid & in_ready;

    rojoblaze_skid_buf #(
        .pkt_t (decode_pkt_t)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid & ~hazard),
        .in_ready  (skid_ready),
        .in_pkt    (dec_pkt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pkt   (out_pkt_s)
    );

    assign out_pkt = out_pkt_s;

    // Interrupt enable follows bit 0 of an accepted ENABLE/DISABLE or RETURNI, unless flushed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            int_enable <= 1'b0;
        else if (accept && !flush && (opc == INTERRUPT_SET || opc == RETURN_I_SET))
            int_enable <= in_instr[0];
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign out_illegal = out_pkt_s.illegal;

    // Saturating count of accepted illegal opcodes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            illegal_cnt <= 8'h00;
        else if (accept && !flush && dec_pkt.illegal && illegal_cnt != 8'hFF)
            illegal_cnt <= illegal_cnt + 8'h01;
    end
`endif

endmodule
